// File: rtl/fencing_bout_referee.sv
// rtl/fencing_bout_referee.sv - two-player saber bout controller
// Per-player attack FSMs, touch qualification, lockout/pause timing and scoring.
module fencing_bout_referee #(
  parameter int ATTACK_FRAMES   = 12,
  parameter int RECOVERY_FRAMES = 8,
  parameter int LOCKOUT_FRAMES  = 4,
  parameter int PAUSE_FRAMES    = 60,
  parameter int POINTS_TO_WIN   = 5
) (
  input  logic       clk_pixel_in,
  input  logic       rst_n_in,
  input  logic       frame_start_in,
  input  logic       start_bout_in,
  input  logic       p1_attack_req_in,
  input  logic       p2_attack_req_in,
  input  logic       p1_blocking_in,
  input  logic       p2_blocking_in,
  input  logic       p1_hit_in,
  input  logic       p2_hit_in,
  output logic       p1_is_attacking_out,
  output logic       p2_is_attacking_out,
  output logic [3:0] p1_score_out,
  output logic [3:0] p2_score_out,
  output logic       p1_touch_out,
  output logic       p2_touch_out,
  output logic [2:0] bout_state_out,
  output logic [1:0] winner_out
);

  typedef enum logic [2:0] {
    B_WAIT  = 3'd0,
    B_FIGHT = 3'd1,
    B_LOCK  = 3'd2,
    B_PAUSE = 3'd3,
    B_DONE  = 3'd4
  } bout_e;

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_ATTACK  = 2'd1,
    P_RECOVER = 2'd2
  } plr_e;

  bout_e            bout_q, bout_d;
  logic [7:0]       bcnt_q, bcnt_d;
  plr_e             p_state_q [2];
  plr_e             p_state_d [2];
  logic [1:0][7:0]  p_cnt_q, p_cnt_d;
  logic [1:0][3:0]  score_q, score_d;
  logic [1:0]       scored_q, scored_d;
  logic [1:0]       touch_q, touch_d;

  logic [1:0] req, blk, hit, qual, reached;
  logic       bout_live;

  assign req = {p2_attack_req_in, p1_attack_req_in};
  assign blk = {p2_blocking_in, p1_blocking_in};
  assign hit = {p2_hit_in, p1_hit_in};

  assign bout_live = (bout_q == B_FIGHT) || (bout_q == B_LOCK);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      qual[i]    = hit[i] && (p_state_q[i] == P_ATTACK) && bout_live && !scored_q[i];
      reached[i] = score_q[i] >= 4'(POINTS_TO_WIN);
    end
  end

  always_comb begin
    bout_d    = bout_q;
    bcnt_d    = bcnt_q;
    score_d   = score_q;
    scored_d  = scored_q;
    touch_d   = 2'b00;
    p_state_d = p_state_q;
    p_cnt_d   = p_cnt_q;

    for (int i = 0; i < 2; i++) begin
      if (qual[i]) begin
        touch_d[i]  = 1'b1;
        scored_d[i] = 1'b1;
        if (score_q[i] != 4'hF) score_d[i] = score_q[i] + 4'd1;
      end
    end

    case (bout_q)
      B_WAIT, B_DONE: begin
        if (start_bout_in) begin
          bout_d   = B_FIGHT;
          bcnt_d   = 8'd0;
          score_d  = '0;
          scored_d = 2'b00;
        end
      end
      B_FIGHT: begin
        if (&qual) begin
          bout_d = B_PAUSE;
          bcnt_d = 8'(PAUSE_FRAMES);
        end else if (|qual) begin
          bout_d = B_LOCK;
          bcnt_d = 8'(LOCKOUT_FRAMES);
        end
      end
      B_LOCK: begin
        if ((|qual) || (frame_start_in && bcnt_q == 8'd1)) begin
          bout_d = B_PAUSE;
          bcnt_d = 8'(PAUSE_FRAMES);
        end else if (frame_start_in) begin
          bcnt_d = bcnt_q - 8'd1;
        end
      end
      B_PAUSE: begin
        if (frame_start_in && bcnt_q == 8'd1) begin
          bcnt_d = 8'd0;
          if (|reached) begin
            bout_d = B_DONE;
          end else begin
            bout_d   = B_FIGHT;
            scored_d = 2'b00;
          end
        end else if (frame_start_in) begin
          bcnt_d = bcnt_q - 8'd1;
        end
      end
      default: begin
        bout_d = B_WAIT;
        bcnt_d = 8'd0;
      end
    endcase

    // Players only move while the exchange is live; any other bout state parks them.
    for (int i = 0; i < 2; i++) begin
      if (!(bout_d == B_FIGHT || bout_d == B_LOCK)) begin
        p_state_d[i] = P_IDLE;
        p_cnt_d[i]   = 8'd0;
      end else begin
        case (p_state_q[i])
          P_IDLE: begin
            if (req[i] && !blk[i] && bout_q == B_FIGHT) begin
              p_state_d[i] = P_ATTACK;
              p_cnt_d[i]   = 8'(ATTACK_FRAMES);
            end
          end
          P_ATTACK: begin
            if (frame_start_in && p_cnt_q[i] == 8'd1) begin
              p_state_d[i] = P_RECOVER;
              p_cnt_d[i]   = 8'(RECOVERY_FRAMES);
            end else if (frame_start_in) begin
              p_cnt_d[i] = p_cnt_q[i] - 8'd1;
            end
          end
          P_RECOVER: begin
            if (frame_start_in && p_cnt_q[i] == 8'd1) begin
              p_state_d[i] = P_IDLE;
              p_cnt_d[i]   = 8'd0;
            end else if (frame_start_in) begin
              p_cnt_d[i] = p_cnt_q[i] - 8'd1;
            end
          end
          default: begin
            p_state_d[i] = P_IDLE;
            p_cnt_d[i]   = 8'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bout_q    <= B_WAIT;
      bcnt_q    <= 8'd0;
      p_state_q <= '{P_IDLE, P_IDLE};
      p_cnt_q   <= '0;
      score_q   <= '0;
      scored_q  <= 2'b00;
      touch_q   <= 2'b00;
    end else begin
      bout_q    <= bout_d;
      bcnt_q    <= bcnt_d;
      p_state_q <= p_state_d;
      p_cnt_q   <= p_cnt_d;
      score_q   <= score_d;
      scored_q  <= scored_d;
      touch_q   <= touch_d;
    end
  end

  assign p1_is_attacking_out = (p_state_q[0] == P_ATTACK);
  assign p2_is_attacking_out = (p_state_q[1] == P_ATTACK);
  assign p1_score_out        = score_q[0];
  assign p2_score_out        = score_q[1];
  assign p1_touch_out        = touch_q[0];
  assign p2_touch_out        = touch_q[1];
  assign bout_state_out      = bout_q;
  assign winner_out          = (bout_q == B_DONE) ? reached : 2'b00;

endmodule

// File: tb/tb_fencing_bout_referee.sv
// tb/tb_fencing_bout_referee.sv - randomized bench against a behavioural bout model
module tb_fencing_bout_referee;

  localparam int ATT = 12, REC = 8, LOCK = 4, PAUSE = 60, WIN = 5;
  localparam int NCYC = 30000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame, start;
  logic       req1, req2, blk1, blk2, hit1, hit2;
  logic       att1, att2, touch1, touch2;
  logic [3:0] score1, score2;
  logic [2:0] bstate;
  logic [1:0] winner;

  always #5 clk = ~clk;

  fencing_bout_referee #(
    .ATTACK_FRAMES(ATT), .RECOVERY_FRAMES(REC), .LOCKOUT_FRAMES(LOCK),
    .PAUSE_FRAMES(PAUSE), .POINTS_TO_WIN(WIN)
  ) dut (
    .clk_pixel_in(clk), .rst_n_in(rst_n), .frame_start_in(frame),
    .start_bout_in(start),
    .p1_attack_req_in(req1), .p2_attack_req_in(req2),
    .p1_blocking_in(blk1), .p2_blocking_in(blk2),
    .p1_hit_in(hit1), .p2_hit_in(hit2),
    .p1_is_attacking_out(att1), .p2_is_attacking_out(att2),
    .p1_score_out(score1), .p2_score_out(score2),
    .p1_touch_out(touch1), .p2_touch_out(touch2),
    .bout_state_out(bstate), .winner_out(winner)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bout phases: 0 wait, 1 fight, 2 lockout, 3 pause, 4 done.
  // Player phases: 0 idle, 1 attacking, 2 recovering; timers hold frames left.
  int m_bout, m_btimer;
  int m_phase [2];
  int m_left  [2];
  int m_score [2];
  bit m_scored [2];
  bit m_touch  [2];
  int n_done, n_draw, n_touch;

  task automatic model_reset();
    m_bout = 0;
    m_btimer = 0;
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_left[i] = 0; m_score[i] = 0;
      m_scored[i] = 0; m_touch[i] = 0;
    end
  endtask

  task automatic model_step();
    bit q [2];
    bit rq [2];
    bit bk [2];
    bit ht [2];
    int nb;
    bit live_next;
    rq[0] = req1; rq[1] = req2;
    bk[0] = blk1; bk[1] = blk2;
    ht[0] = hit1; ht[1] = hit2;
    for (int i = 0; i < 2; i++) begin
      q[i] = ht[i] && m_phase[i] == 1 && (m_bout == 1 || m_bout == 2) && !m_scored[i];
      m_touch[i] = q[i];
      if (q[i]) begin
        m_scored[i] = 1;
        m_score[i] = (m_score[i] + 1 > 15) ? 15 : m_score[i] + 1;
        n_touch++;
      end
    end
    nb = m_bout;
    if (m_bout == 0 || m_bout == 4) begin
      if (start) begin
        nb = 1;
        m_score[0] = 0; m_score[1] = 0;
        m_scored[0] = 0; m_scored[1] = 0;
      end
    end else if (m_bout == 1) begin
      if (q[0] && q[1]) begin nb = 3; m_btimer = PAUSE; end
      else if (q[0] || q[1]) begin nb = 2; m_btimer = LOCK; end
    end else if (m_bout == 2) begin
      if (q[0] || q[1] || (frame && m_btimer == 1)) begin nb = 3; m_btimer = PAUSE; end
      else if (frame) m_btimer--;
    end else if (m_bout == 3) begin
      if (frame && m_btimer == 1) begin
        m_btimer = 0;
        if (m_score[0] >= WIN || m_score[1] >= WIN) begin
          nb = 4;
          n_done++;
          if (m_score[0] >= WIN && m_score[1] >= WIN) n_draw++;
        end else begin
          nb = 1;
          m_scored[0] = 0; m_scored[1] = 0;
        end
      end else if (frame) m_btimer--;
    end
    live_next = (nb == 1 || nb == 2);
    for (int i = 0; i < 2; i++) begin
      if (!live_next) begin
        m_phase[i] = 0; m_left[i] = 0;
      end else if (m_phase[i] == 0) begin
        if (rq[i] && !bk[i] && m_bout == 1) begin m_phase[i] = 1; m_left[i] = ATT; end
      end else if (frame) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          if (m_phase[i] == 1) begin m_phase[i] = 2; m_left[i] = REC; end
          else m_phase[i] = 0;
        end
      end
    end
    m_bout = nb;
  endtask

  task automatic check_outputs();
    logic [1:0] w;
    w = 2'b00;
    if (m_bout == 4) w = {1'(m_score[1] >= WIN), 1'(m_score[0] >= WIN)};
    check_eq("bout_state", bstate, m_bout);
    check_eq("p1_score", score1, m_score[0]);
    check_eq("p2_score", score2, m_score[1]);
    check_eq("touch", {touch2, touch1}, {m_touch[1], m_touch[0]});
    check_eq("attacking", {att2, att1}, {m_phase[1] == 1, m_phase[0] == 1});
    check_eq("winner", winner, w);
  endtask

  task automatic zero_inputs();
    frame = 0; start = 0; req1 = 0; req2 = 0;
    blk1 = 0; blk2 = 0; hit1 = 0; hit2 = 0;
  endtask

  initial begin
    int resets_done;
    n_done = 0; n_draw = 0; n_touch = 0;
    resets_done = 0;
    rst_n = 1'b0;
    zero_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    start = 1'b1;
    model_step();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;
      if (resets_done < 2 && cyc > 8000 * (resets_done + 1) && m_phase[0] == 1) begin
        // Asynchronous reset mid-attack, asserted between clock edges.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_reset_attacking", {att2, att1}, 2'b00);
        check_eq("async_reset_bout", bstate, 0);
        check_eq("async_reset_scores", {score2, score1}, 8'd0);
        zero_inputs();
        resets_done++;
        continue;
      end
      frame = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 29) == 0);
      req1  = ($urandom_range(0, 9) == 0);
      req2  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) blk1 = ~blk1;
      if ($urandom_range(0, 9) == 0) blk2 = ~blk2;
      if ($urandom_range(0, 5) == 0) hit1 = ~hit1;
      if ($urandom_range(0, 5) == 0) hit2 = ~hit2;
      model_step();
    end
    @(negedge clk);
    check_outputs();
    check_eq("some_touches_seen", n_touch > 0, 1);
    check_eq("some_bouts_finished", n_done > 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fencing_bout_referee.md
Name: fencing_bout_referee

Overview:
- Two-player bout controller for the saber datapath.
- Per-player attack FSMs produce the is_attacking strobes that gate the saber collision detectors, one detector per attacker direction.
- Consumes the detectors' collision levels and applies touch qualification, a double-touch lockout window, a post-touch pause and scoring to POINTS_TO_WIN.
- All timing counts frames (frame_start_in pulses), not pixel clocks.

Parameters:
- ATTACK_FRAMES, 12, frames a player stays in ATTACK after a request (legal range 1..255).
- RECOVERY_FRAMES, 8, frames in RECOVER before a new attack is accepted (1..255).
- LOCKOUT_FRAMES, 4, double-touch window after the first touch (1..255).
- PAUSE_FRAMES, 60, freeze after a touch resolves (1..255).
- POINTS_TO_WIN, 5, score that ends the bout (1..15).

Ports:
- clk_pixel_in  in  1  pixel clock.
- rst_n_in  in  1  asynchronous active-low reset.
- frame_start_in  in  1  one-cycle pulse per frame; all frame counters advance only on this.
- start_bout_in  in  1  pulse; starts or restarts the bout from WAIT_START or DONE.
- p1_attack_req_in, p2_attack_req_in  in  1 each  level attack request.
- p1_blocking_in, p2_blocking_in  in  1 each  level; a blocking player cannot start an attack.
- p1_hit_in, p2_hit_in  in  1 each  collision level from the detector for that player's attack.
- p1_is_attacking_out, p2_is_attacking_out  out  1 each  high while that player is in ATTACK.
- p1_score_out, p2_score_out  out  4 each  current score.
- p1_touch_out, p2_touch_out  out  1 each  one-cycle pulse when that player is awarded a touch.
- bout_state_out  out  3  WAIT_START=0, FIGHT=1, LOCKOUT=2, PAUSE=3, DONE=4.
- winner_out  out  2  00 none, 01 p1, 10 p2, 11 draw; valid only in DONE, 00 otherwise.

Behaviour:
Reset values:
- Async assert of rst_n_in clears everything immediately, including mid-attack and mid-lockout.
- Reset state: bout WAIT_START; both player FSMs IDLE; all outputs 0; all counters 0.

Player FSM (one per player, identical):
- IDLE -> ATTACK: on a clock with req=1, blocking=0 and bout in FIGHT. is_attacking rises the next cycle; counter loads ATTACK_FRAMES.
- ATTACK: counter decrements on frame_start_in. On frame_start_in with counter==1 -> RECOVER, counter loads RECOVERY_FRAMES.
- RECOVER -> IDLE: same rule (frame_start_in with counter==1).
- Requests seen in ATTACK or RECOVER are dropped, not queued.
- Both player FSMs are forced to IDLE on entry to PAUSE, DONE or WAIT_START.

Touch qualification:
- A player's hit qualifies only when all hold: hit_in=1, that player is in ATTACK, bout is FIGHT or LOCKOUT, and the player has not already scored in the current exchange.
- Collision is a level; only the first qualifying cycle counts.
- A touch increments that score (saturates at 15) and pulses the player's touch_out in the cycle after the qualifying hit.

Bout FSM:
- WAIT_START: start_bout_in -> FIGHT; clear scores.
- FIGHT, one player qualifies: that player scores, bout -> LOCKOUT, counter loads LOCKOUT_FRAMES.
- FIGHT, both qualify in the same cycle: both score, bout -> PAUSE directly.
- LOCKOUT, opponent qualifies: opponent scores, bout -> PAUSE immediately.
- LOCKOUT expiry (frame_start_in with counter==1): bout -> PAUSE.
- During LOCKOUT the player FSMs keep running, but new attack requests are not accepted.
- PAUSE: loads PAUSE_FRAMES. On expiry:
  - either score >= POINTS_TO_WIN -> DONE;
  - otherwise -> FIGHT, and the per-exchange scored flags clear.
- DONE: winner_out is 01 or 10 for the single player at or above POINTS_TO_WIN, 11 if both are. start_bout_in -> FIGHT with scores cleared and winner_out 00.
- start_bout_in in FIGHT, LOCKOUT or PAUSE is ignored.

Frame pulse coincidence:
- A frame_start_in in the same cycle as a state entry does not decrement the freshly loaded counter.

Test Plan:
- Reset, then start_bout_in; assert p1 req for 1 cycle -> p1_is_attacking_out high from the next cycle for exactly 12 frame pulses, then low; a p1 req during the following 8 frames is ignored.
- p1 attacking, p1_hit_in high for 50 cycles -> exactly one p1_touch_out pulse, p1_score=1, state LOCKOUT; no p2 hit -> PAUSE after 4 frames, FIGHT after 60 more.
- p1 touch, then p2 (in ATTACK) hit in frame 2 of LOCKOUT -> p2_touch pulse, scores 1/1, immediate PAUSE.
- p1_hit_in and p2_hit_in qualify in the same cycle -> both touch pulses in the same cycle, both scores +1, state PAUSE with no LOCKOUT.
- Blocking p2 and p1_hit_in while p1 in RECOVER -> no attack start and no score; p2_hit_in with p2 IDLE -> no score.
- Run to 4-4, then a double touch -> DONE, winner_out=11; start_bout_in -> scores 0, FIGHT. Assert rst_n_in low mid-ATTACK -> all outputs 0 asynchronously, state WAIT_START.
